// File: rtl/vec_pkg.sv
// Shared types for the vector command issuer: opcodes, FSM states and the queued command record.
package vec_pkg;

  localparam logic [6:0] VADD = 7'h00;
  localparam logic [6:0] VSUB = 7'h01;
  localparam logic [6:0] VMUL = 7'h02;
  localparam logic [6:0] VLE  = 7'h40;
  localparam logic [6:0] VSE  = 7'h20;

  localparam int unsigned CMD_W = 51;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StGap,
    StHalt
  } state_e;

  typedef struct packed {
    logic [6:0]  funct;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic [4:0]  vr;
    logic [24:0] vl;
    logic [3:0]  tag;
  } cmd_t;

  function automatic logic funct_legal(input logic [6:0] f);
    case (f)
      VADD, VSUB, VMUL, VLE, VSE: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/vec_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit to tell full from empty.
module vec_cmd_fifo
  import vec_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [CMD_W-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [CMD_W-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vec_cmd_issuer.sv
// Queues vector commands and issues them one at a time to the vector unit's start/done port,
// tracking each to completion or timeout and reporting status per tag.
module vec_cmd_issuer
  import vec_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_funct,
  input  logic [4:0]  cmd_vs1,
  input  logic [4:0]  cmd_vs2,
  input  logic [4:0]  cmd_vr,
  input  logic [24:0] cmd_vl,
  input  logic [3:0]  cmd_tag,
  input  logic        flush,
  output logic [6:0]  vu_funct,
  output logic [4:0]  vu_vs1,
  output logic [4:0]  vu_vs2,
  output logic [4:0]  vu_vr,
  output logic [24:0] vu_vl,
  output logic        vu_start,
  input  logic        vu_done,
  output logic        done_valid,
  output logic [3:0]  done_tag,
  output logic        illegal,
  output logic        timeout_err,
  output logic        busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  cmd_t            cur_q, cur_d;
  logic            done_valid_q, done_valid_d;
  logic [3:0]      done_tag_q, done_tag_d;
  logic            illegal_q, illegal_d;
  logic            timeout_q, timeout_d;

  cmd_t             in_cmd, head;
  logic [CMD_W-1:0] head_raw;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;

  assign in_cmd = '{funct: cmd_funct, vs1: cmd_vs1, vs2: cmd_vs2, vr: cmd_vr,
                    vl: cmd_vl, tag: cmd_tag};
  assign head   = cmd_t'(head_raw);

  assign cmd_ready = !fifo_full && (state_q != StHalt);
  assign fifo_push = cmd_valid && cmd_ready && !flush;

  vec_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (fifo_push),
    .wdata(in_cmd),
    .pop  (fifo_pop),
    .flush(flush),
    .rdata(head_raw),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_d        = cur_q;
    done_valid_d = 1'b0;
    done_tag_d   = done_tag_q;
    illegal_d    = 1'b0;
    timeout_d    = timeout_q;
    fifo_pop     = 1'b0;

    if (flush) timeout_d = 1'b0;

    case (state_q)
      StIdle: begin
        // A flush in the same cycle must not let the head slip out before it is dropped.
        if (!fifo_empty && !flush) begin
          fifo_pop = 1'b1;
          cur_d    = head;
          if (!funct_legal(head.funct)) begin
            illegal_d  = 1'b1;
            done_tag_d = head.tag;
          end else if (head.vl == '0) begin
            done_valid_d = 1'b1;
            done_tag_d   = head.tag;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // Done on the terminal count still wins over the timeout.
        if (vu_done) begin
          done_valid_d = 1'b1;
          done_tag_d   = cur_q.tag;
          state_d      = StGap;
        end else if (cnt_q == CntLast) begin
          timeout_d  = 1'b1;
          done_tag_d = cur_q.tag;
          state_d    = StHalt;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      StHalt: begin
        if (flush) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      cur_q        <= '0;
      done_valid_q <= 1'b0;
      done_tag_q   <= '0;
      illegal_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      done_valid_q <= done_valid_d;
      done_tag_q   <= done_tag_d;
      illegal_q    <= illegal_d;
      timeout_q    <= timeout_d;
    end
  end

  assign vu_funct    = cur_q.funct;
  assign vu_vs1      = cur_q.vs1;
  assign vu_vs2      = cur_q.vs2;
  assign vu_vr       = cur_q.vr;
  assign vu_vl       = cur_q.vl;
  assign vu_start    = (state_q == StIssue);
  assign done_valid  = done_valid_q;
  assign done_tag    = done_tag_q;
  assign illegal     = illegal_q;
  assign timeout_err = timeout_q;
  assign busy        = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_vec_cmd_issuer.sv
// Directed bench for vec_cmd_issuer with a simple fixed-latency vector unit responder.
module tb_vec_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [6:0]  cmd_funct;
  logic [4:0]  cmd_vs1, cmd_vs2, cmd_vr;
  logic [24:0] cmd_vl;
  logic [3:0]  cmd_tag;
  logic        flush;
  logic [6:0]  vu_funct;
  logic [4:0]  vu_vs1, vu_vs2, vu_vr;
  logic [24:0] vu_vl;
  logic        vu_start, vu_done;
  logic        done_valid, illegal, timeout_err, busy;
  logic [3:0]  done_tag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vec_cmd_issuer #(
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_funct  (cmd_funct),
    .cmd_vs1    (cmd_vs1),
    .cmd_vs2    (cmd_vs2),
    .cmd_vr     (cmd_vr),
    .cmd_vl     (cmd_vl),
    .cmd_tag    (cmd_tag),
    .flush      (flush),
    .vu_funct   (vu_funct),
    .vu_vs1     (vu_vs1),
    .vu_vs2     (vu_vs2),
    .vu_vr      (vu_vr),
    .vu_vl      (vu_vl),
    .vu_start   (vu_start),
    .vu_done    (vu_done),
    .done_valid (done_valid),
    .done_tag   (done_tag),
    .illegal    (illegal),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  // Unit model: pulse done 'lat' cycles after the start pulse.
  bit   resp_en = 1'b0;
  int   lat = 3;
  int   rem = 0;
  logic auto_done = 1'b0;
  assign vu_done = auto_done;

  always @(negedge clk) begin
    auto_done = 1'b0;
    if (!resp_en) rem = 0;
    else if (vu_start) rem = lat;
    else if (rem > 0) begin
      rem--;
      if (rem == 0) auto_done = 1'b1;
    end
  end

  logic [3:0] done_q[$];
  logic [3:0] ill_q[$];
  int         nstart = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done_valid) done_q.push_back(done_tag);
      if (illegal)    ill_q.push_back(done_tag);
      if (vu_start)   nstart++;
    end
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic push(input logic [6:0] f, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [4:0] r, input logic [24:0] l, input logic [3:0] t);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_funct = f;
    cmd_vs1   = s1;
    cmd_vs2   = s2;
    cmd_vr    = r;
    cmd_vl    = l;
    cmd_tag   = t;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", cmd_ready, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", busy, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  int d0, i0, s0;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_funct = '0; cmd_vs1 = '0; cmd_vs2 = '0;
    cmd_vr = '0; cmd_vl = '0; cmd_tag = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 32'd1);
    chk("rst_start", vu_start, 32'd0);
    chk("rst_funct", vu_funct, 32'd0);
    chk("rst_vl", vu_vl, 32'd0);
    chk("rst_done_valid", done_valid, 32'd0);
    chk("rst_done_tag", done_tag, 32'd0);
    chk("rst_illegal", illegal, 32'd0);
    chk("rst_timeout", timeout_err, 32'd0);
    chk("rst_busy", busy, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single VADD, unit answers 3 cycles after start
    resp_en = 1'b1; lat = 3;
    push(7'h00, 5'd1, 5'd2, 5'd3, 25'd4, 4'd5);
    chk("t1_c1_start", vu_start, 32'd0);
    chk("t1_c1_busy", busy, 32'd1);
    @(negedge clk);
    chk("t1_start", vu_start, 32'd1);
    chk("t1_funct", vu_funct, 32'h00);
    chk("t1_vs1", vu_vs1, 32'd1);
    chk("t1_vs2", vu_vs2, 32'd2);
    chk("t1_vr", vu_vr, 32'd3);
    chk("t1_vl", vu_vl, 32'd4);
    @(negedge clk);
    chk("t1_start_pulse", vu_start, 32'd0);
    chk("t1_vl_hold", vu_vl, 32'd4);
    repeat (3) @(negedge clk);
    chk("t1_done_valid", done_valid, 32'd1);
    chk("t1_done_tag", done_tag, 32'd5);
    chk("t1_gap_busy", busy, 32'd1);
    @(negedge clk);
    chk("t1_done_pulse", done_valid, 32'd0);
    chk("t1_idle_busy", busy, 32'd0);

    // Backpressure: one in flight, four queued, fifth held by the source
    lat = 6; d0 = done_q.size();
    push(7'h00, 5'd0, 5'd0, 5'd0, 25'd8, 4'd0);
    for (int t = 1; t <= 4; t++) push(7'h02, 5'd1, 5'd1, 5'd1, 25'd8, 4'(t));
    chk("t2_full_ready", cmd_ready, 32'd0);
    chk("t2_full_busy", busy, 32'd1);
    push(7'h01, 5'd2, 5'd2, 5'd2, 25'd8, 4'd5);
    wait_idle();
    chk("t2_count", done_q.size() - d0, 32'd6);
    for (int i = 0; i < 6; i++) chk("t2_order", done_q[d0 + i], 32'(i));

    // Illegal opcode then zero-length command
    s0 = nstart; d0 = done_q.size(); i0 = ill_q.size();
    push(7'h7F, 5'd0, 5'd0, 5'd0, 25'd4, 4'd9);
    push(7'h00, 5'd0, 5'd0, 5'd0, 25'd0, 4'd10);
    chk("t3_illegal", illegal, 32'd1);
    chk("t3_ill_tag", done_tag, 32'd9);
    chk("t3_ill_no_done", done_valid, 32'd0);
    @(negedge clk);
    chk("t3_vl0_done", done_valid, 32'd1);
    chk("t3_vl0_tag", done_tag, 32'd10);
    chk("t3_ill_pulse", illegal, 32'd0);
    wait_idle();
    chk("t3_no_start", nstart - s0, 32'd0);
    chk("t3_ill_count", ill_q.size() - i0, 32'd1);
    chk("t3_done_count", done_q.size() - d0, 32'd1);

    // Unit never answers: timeout after 16 WAIT cycles, then flush recovers
    resp_en = 1'b0;
    push(7'h02, 5'd4, 5'd5, 5'd6, 25'd3, 4'd7);
    repeat (17) @(negedge clk);
    chk("t4_before_timeout", timeout_err, 32'd0);
    chk("t4_busy", busy, 32'd1);
    @(negedge clk);
    chk("t4_timeout", timeout_err, 32'd1);
    chk("t4_halt_ready", cmd_ready, 32'd0);
    chk("t4_timeout_tag", done_tag, 32'd7);
    chk("t4_no_done", done_valid, 32'd0);
    flush = 1'b1;
    cmd_valid = 1'b1; cmd_funct = 7'h00; cmd_vl = 25'd2; cmd_tag = 4'd12;
    @(negedge clk);
    flush = 1'b0; cmd_valid = 1'b0;
    chk("t4_flush_err", timeout_err, 32'd0);
    chk("t4_flush_ready", cmd_ready, 32'd1);
    chk("t4_flush_busy", busy, 32'd0);
    s0 = nstart;
    repeat (4) @(negedge clk);
    chk("t4_no_issue", nstart - s0, 32'd0);

    // Done lands exactly on the terminal count
    resp_en = 1'b1; lat = 16;
    push(7'h20, 5'd7, 5'd8, 5'd9, 25'd5, 4'd11);
    repeat (18) @(negedge clk);
    chk("t5_done_valid", done_valid, 32'd1);
    chk("t5_done_tag", done_tag, 32'd11);
    chk("t5_no_timeout", timeout_err, 32'd0);
    wait_idle();
    chk("t5_err_after", timeout_err, 32'd0);

    // Flush during WAIT with two queued and a concurrent push
    lat = 8; s0 = nstart; d0 = done_q.size();
    push(7'h00, 5'd1, 5'd1, 5'd1, 25'd6, 4'd1);
    push(7'h00, 5'd1, 5'd1, 5'd1, 25'd6, 4'd2);
    push(7'h00, 5'd1, 5'd1, 5'd1, 25'd6, 4'd3);
    flush = 1'b1;
    cmd_valid = 1'b1; cmd_tag = 4'd4;
    @(negedge clk);
    flush = 1'b0; cmd_valid = 1'b0;
    chk("t6_inflight_busy", busy, 32'd1);
    wait_idle();
    chk("t6_one_start", nstart - s0, 32'd1);
    chk("t6_done_count", done_q.size() - d0, 32'd1);
    chk("t6_done_tag", done_q[d0], 32'd1);
    chk("t6_ready", cmd_ready, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
